seq_multiplier: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 21 ++
 rtl/seq_mul_ctrl.sv | 82 ++++++++
 rtl/seq_mul_dp.sv | 48 ++++
 rtl/seq_multiplier.sv | 51 +++++
 tb/tb_seq_multiplier.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential repeated-addition multiplier:
// controller states, operand/product widths and the accumulator extension helper.
package seq_mul_pkg;

   localparam int OP_W   = 32;
   localparam int PROD_W = 64;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDM  = 3'd1,
      LDQ  = 3'd2,
      CHK  = 3'd3,
      ADD  = 3'd4,
      DONE = 3'd5
   } state_t;

   function automatic logic [PROD_W-1:0] zero_ext(input logic [OP_W-1:0] val);
      return {{(PROD_W-OP_W){1'b0}}, val};
   endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Controller FSM: sequences operand loads, the add/decrement loop and the
// done handshake from datapath status flags.
module seq_mul_ctrl
   import seq_mul_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic eqz_m,
   input  logic neqz_m,
   input  logic eqz_q,
   input  logic neqz_q,
   input  logic q_one,
   output logic ld_m,
   output logic ld_q,
   output logic clr_p,
   output logic add_en,
   output logic dec_q,
   output logic done
);

   state_t state_r;
   state_t state_nxt_s;
   logic   done_r;

   // State register; done is registered from the next state so it lines up with DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= (state_nxt_s == DONE);
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_nxt_s = state_r;
      ld_m        = 1'b0;
      ld_q        = 1'b0;
      clr_p       = 1'b0;
      add_en      = 1'b0;
      dec_q       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = LDM;
            else       state_nxt_s = IDLE;
         end
         LDM: begin
            ld_m        = 1'b1;
            state_nxt_s = LDQ;
         end
         LDQ: begin
            ld_q        = 1'b1;
            clr_p       = 1'b1;
            state_nxt_s = CHK;
         end
         CHK: begin
            if (eqz_m || eqz_q) state_nxt_s = DONE;
            else                state_nxt_s = ADD;
         end
         ADD: begin
            // Never accumulate or decrement past zero, even if Q was corrupted
            add_en = neqz_m & neqz_q;
            dec_q  = neqz_m & neqz_q;
            if (q_one || eqz_q) state_nxt_s = DONE;
            else                state_nxt_s = ADD;
         end
         DONE: begin
            if (start) state_nxt_s = DONE;
            else       state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign done = done_r;

endmodule

// File: rtl/seq_mul_dp.sv
// Datapath: operand registers, 64-bit accumulator, multiplier down-counter
// and the zero/one status compares consumed by the controller.
module seq_mul_dp
   import seq_mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [OP_W-1:0]   data_in,
   input  logic              ld_m,
   input  logic              ld_q,
   input  logic              clr_p,
   input  logic              add_en,
   input  logic              dec_q,
   output logic              eqz_m,
   output logic              neqz_m,
   output logic              eqz_q,
   output logic              neqz_q,
   output logic              q_one,
   output logic [PROD_W-1:0] product
);

   logic [OP_W-1:0]   m_r;
   logic [OP_W-1:0]   q_r;
   logic [PROD_W-1:0] p_r;

   // Operand, counter and accumulator registers; all hold when no strobe is active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r <= {OP_W{1'b0}};
         q_r <= {OP_W{1'b0}};
         p_r <= {PROD_W{1'b0}};
      end else begin
         if (ld_m) m_r <= data_in;
         if (ld_q)       q_r <= data_in;
         else if (dec_q) q_r <= q_r - 32'd1;
         if (clr_p)       p_r <= {PROD_W{1'b0}};
         else if (add_en) p_r <= p_r + zero_ext(m_r);
      end
   end

   assign eqz_m   = (m_r == {OP_W{1'b0}});
   assign neqz_m  = ~eqz_m;
   assign eqz_q   = (q_r == {OP_W{1'b0}});
   assign neqz_q  = ~eqz_q;
   assign q_one   = (q_r == 32'd1);
   assign product = p_r;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 32x32 unsigned multiplier by repeated addition; the top level
// only connects the controller to the datapath.
module seq_multiplier
   import seq_mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   data_in,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   logic ld_m_s, ld_q_s, clr_p_s, add_en_s, dec_q_s;
   logic eqz_m_s, neqz_m_s, eqz_q_s, neqz_q_s, q_one_s;

   seq_mul_ctrl u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .eqz_m  (eqz_m_s),
      .neqz_m (neqz_m_s),
      .eqz_q  (eqz_q_s),
      .neqz_q (neqz_q_s),
      .q_one  (q_one_s),
      .ld_m   (ld_m_s),
      .ld_q   (ld_q_s),
      .clr_p  (clr_p_s),
      .add_en (add_en_s),
      .dec_q  (dec_q_s),
      .done   (done)
   );

   seq_mul_dp u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .ld_m    (ld_m_s),
      .ld_q    (ld_q_s),
      .clr_p   (clr_p_s),
      .add_en  (add_en_s),
      .dec_q   (dec_q_s),
      .eqz_m   (eqz_m_s),
      .neqz_m  (neqz_m_s),
      .eqz_q   (eqz_q_s),
      .neqz_q  (neqz_q_s),
      .q_one   (q_one_s),
      .product (product)
   );

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed runs push hand-computed products,
// a negedge monitor pops and compares whenever done rises.
module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] data_in;
   logic        done;
   logic [63:0] product;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_cur = 64'd0;
   logic        done_prev = 1'b0;

   seq_multiplier dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .data_in (data_in),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop on done rising, then require product to hold while done stays high
   always @(negedge clk) begin
      if (rst_n) begin
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_done: done=1 with no pending result, product=0x%0h", product);
            end else begin
               exp_cur = exp_q.pop_front();
               chk("product", product, exp_cur);
            end
         end else if (done) begin
            chk("product_hold", product, exp_cur);
         end
      end
      done_prev = done;
   end

   task automatic run_mul(input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp_p, input int exp_lat, input bit glitch);
      int e;
      bit seen;
      @(negedge clk);
      chk("idle_done", {63'd0, done}, 64'd0);
      exp_q.push_back(exp_p);
      start = 1'b1;
      @(posedge clk);                 // edge 0
      @(negedge clk) data_in = m;
      @(posedge clk);                 // edge 1
      @(negedge clk) data_in = q;
      @(posedge clk);                 // edge 2
      e = 2;
      seen = 1'b0;
      while (!seen && e < exp_lat + 20) begin
         @(negedge clk);
         if (glitch) data_in = $urandom;
         @(posedge clk);
         e++;
         #1;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: done never rose, waited %0d edges, expected edge %0d", e, exp_lat);
      end else begin
         chk("latency", 64'(e), 64'(exp_lat));
      end
      repeat (2) begin
         @(negedge clk);
         chk("done_held", {63'd0, done}, 64'd1);
      end
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      #1;
      chk("done_fall", {63'd0, done}, 64'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      data_in = 32'd0;
      #1;
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_product", product, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_mul(32'd2, 32'd3, 64'd6, 6, 1'b0);
      run_mul(32'd0, 32'd5, 64'd0, 3, 1'b0);
      run_mul(32'd7, 32'd0, 64'd0, 3, 1'b0);
      run_mul(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 4, 1'b0);
      run_mul(32'd4, 32'd5, 64'd20, 8, 1'b0);
      run_mul(32'd6, 32'd7, 64'd42, 10, 1'b0);

      // Reset in the middle of a 3x100 run: edges 4..13 give ten additions
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) data_in = 32'd3;
      @(posedge clk);
      @(negedge clk) data_in = 32'd100;
      @(posedge clk);
      repeat (11) @(posedge clk);
      #1;
      chk("mid_add_partial", product, 64'd30);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_done", {63'd0, done}, 64'd0);
      chk("async_rst_product", product, 64'd0);
      start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_mul(32'd9, 32'd9, 64'd81, 12, 1'b0);

      run_mul(32'd5, 32'd4, 64'd20, 7, 1'b1);

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
